// File: rtl/seg_scan_driver_pkg.sv
// ============================================================================
//  Module      : seg_scan_driver_pkg
//  Description : Shared constants, types and pin-polarity helpers for the
//                4-digit 7-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_driver_pkg;

    localparam int C_NUM_DIGITS          = 4;
    localparam int C_DEFAULT_REFRESH_DIV = 50000;

    typedef logic [1:0] dig_idx_t;

    // Converts logical "on" bits to pin levels for either board polarity.
    function automatic logic [C_NUM_DIGITS-1:0] pin_level(
        input logic [C_NUM_DIGITS-1:0] active,
        input bit                      active_low
    );
        return active_low ? ~active : active;
    endfunction

    function automatic logic pin_level1(input logic active, input bit active_low);
        return active_low ? ~active : active;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_refresh_counter.sv
// ============================================================================
//  Module      : seg_refresh_counter
//  Description : Slot divider and digit index counter; flags the edge that
//                ends each digit slot and the edge that ends the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_refresh_counter
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = C_DEFAULT_REFRESH_DIV
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] dig_idx_nxt_o,
    output logic       slot_start_o,
    output logic       frame_wrap_o
);

    localparam int              CW         = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   C_DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    dig_idx_t      dig_idx_q, dig_idx_d;

    // slot_start_o is high on the edge after which div_cnt reads 0.
    always_comb begin
        slot_start_o = (div_cnt_q == C_DIV_LAST);
        frame_wrap_o = slot_start_o && (dig_idx_q == 2'd3);
        div_cnt_d    = slot_start_o ? '0 : div_cnt_q + CW'(1);
        dig_idx_d    = slot_start_o ? dig_idx_q + 2'd1 : dig_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            dig_idx_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            dig_idx_q <= dig_idx_d;
        end
    end

    assign dig_idx_nxt_o = dig_idx_d;

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed 4-digit scan controller with double-buffered
//                value, dead time, leading-zero blanking and decimal points.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS    = C_NUM_DIGITS,
    parameter int REFRESH_DIV   = C_DEFAULT_REFRESH_DIV,
    parameter bit EN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dot_in,
    input  logic                    blank_lz,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    dp,
    output logic                    frame_done
);

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   pend_dot_q, pend_dot_d, disp_dot_q, disp_dot_d;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic [1:0]              w_idx_nxt;
    logic                    w_slot_start;
    logic                    w_frame_wrap;
    logic [4*NUM_DIGITS-1:0] w_upper;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_blank;
    logic                    w_lit;

    seg_refresh_counter #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh (
        .clk           (clk),
        .rst           (rst),
        .dig_idx_nxt_o (w_idx_nxt),
        .slot_start_o  (w_slot_start),
        .frame_wrap_o  (w_frame_wrap)
    );

    // Outputs are computed from next-cycle state so hex, enable and dot for a
    // slot all appear on the same edge as the counter enters that slot.
    always_comb begin
        pend_val_d = load ? value_in : pend_val_q;
        pend_dot_d = load ? dot_in   : pend_dot_q;
        disp_val_d = w_frame_wrap ? pend_val_q : disp_val_q;
        disp_dot_d = w_frame_wrap ? pend_dot_q : disp_dot_q;

        w_upper  = disp_val_d >> {w_idx_nxt, 2'b00};
        w_blank  = blank_lz && (w_idx_nxt != 2'd0) && (w_upper == '0);
        w_lit    = !w_slot_start && !w_blank;
        w_onehot = '0;
        w_onehot[w_idx_nxt] = 1'b1;

        hex_d        = disp_val_d[{w_idx_nxt, 2'b00} +: 4];
        digit_en_d   = pin_level(w_lit ? w_onehot : '0, EN_ACTIVE_LOW);
        dp_d         = pin_level1(w_lit && disp_dot_d[w_idx_nxt], EN_ACTIVE_LOW);
        frame_done_d = w_frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val_q   <= '0;
            pend_dot_q   <= '0;
            disp_val_q   <= '0;
            disp_dot_q   <= '0;
            hex_q        <= '0;
            digit_en_q   <= pin_level('0, EN_ACTIVE_LOW);
            dp_q         <= pin_level1(1'b0, EN_ACTIVE_LOW);
            frame_done_q <= 1'b0;
        end else begin
            pend_val_q   <= pend_val_d;
            pend_dot_q   <= pend_dot_d;
            disp_val_q   <= disp_val_d;
            disp_dot_q   <= disp_dot_d;
            hex_q        <= hex_d;
            digit_en_q   <= digit_en_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hex        = hex_q;
    assign digit_en   = digit_en_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Directed slot-vector bench for seg_scan_driver, run with
//                REFRESH_DIV=4 and active-low enables.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] value_in = '0;
    logic        load     = 1'b0;
    logic [3:0]  dot_in   = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  hex;
    logic [3:0]  digit_en;
    logic        dp;
    logic        frame_done;

    int n_vec = 0;
    int n_mis = 0;

    seg_scan_driver #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .EN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .dot_in     (dot_in),
        .blank_lz   (blank_lz),
        .hex        (hex),
        .digit_en   (digit_en),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // One record per digit slot: stimulus plus the expected lit-cycle outputs.
    // ld_k is the slot cycle whose closing edge samples load (-1 = no load).
    typedef struct {
        int          ld_k;
        logic [15:0] ld_val;
        logic [3:0]  ld_dot;
        logic        blz;
        logic [3:0]  hex;
        logic [3:0]  en;
        logic        dp;
        logic        fd;
    } slot_vec_t;

    slot_vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int k, input logic [15:0] v, input logic [3:0] d, input logic blz,
                       input logic [3:0] hx, input logic [3:0] en, input logic dpx, input logic fd);
        slot_vec_t s;
        s.ld_k = k; s.ld_val = v; s.ld_dot = d; s.blz = blz;
        s.hex = hx; s.en = en; s.dp = dpx; s.fd = fd;
        vecs.push_back(s);
    endtask

    // Cycle 0 of a slot is dead time; cycles 1..3 carry the lit pattern.
    task automatic run_slot(input slot_vec_t s, input int idx);
        blank_lz = s.blz;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("v%0d.c%0d hex", idx, k), 16'(hex), 16'(s.hex));
            chk($sformatf("v%0d.c%0d digit_en", idx, k), 16'(digit_en), (k == 0) ? 16'hF : 16'(s.en));
            chk($sformatf("v%0d.c%0d dp", idx, k), 16'(dp), (k == 0) ? 16'd1 : 16'(s.dp));
            chk($sformatf("v%0d.c%0d frame_done", idx, k), 16'(frame_done), (k == 0) ? 16'(s.fd) : 16'd0);
            if (k == s.ld_k) begin
                load     = 1'b1;
                value_in = s.ld_val;
                dot_in   = s.ld_dot;
            end
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        // F0: blank display after reset; load 12AF mid-frame
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b1110, 1'b1, 1'b0);
        add( 1, 16'h12AF, 4'h0, 1'b0, 4'h0, 4'b1101, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b1011, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b0111, 1'b1, 1'b0);
        // F1: shows 12AF; pending 1111, then 5555 on the frame boundary edge
        add(-1, 16'h0000, 4'h0, 1'b0, 4'hF, 4'b1110, 1'b1, 1'b1);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'hA, 4'b1101, 1'b1, 1'b0);
        add( 1, 16'h1111, 4'h0, 1'b0, 4'h2, 4'b1011, 1'b1, 1'b0);
        add( 3, 16'h5555, 4'h0, 1'b0, 4'h1, 4'b0111, 1'b1, 1'b0);
        // F2: 1111, F3: 5555 (load 0030 for blanking)
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h1, 4'b1110, 1'b1, 1'b1);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h1, 4'b1101, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h1, 4'b1011, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h1, 4'b0111, 1'b1, 1'b0);
        add( 1, 16'h0030, 4'h0, 1'b0, 4'h5, 4'b1110, 1'b1, 1'b1);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h5, 4'b1101, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h5, 4'b1011, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h5, 4'b0111, 1'b1, 1'b0);
        // F4: 0030 blanked; load 0000 with dots 0101
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1110, 1'b1, 1'b1);
        add( 1, 16'h0000, 4'h5, 1'b1, 4'h3, 4'b1101, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0);
        // F5: 0000 blanked, only digit 0 lit with its dot
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1110, 1'b0, 1'b1);
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b1, 4'h0, 4'b1111, 1'b1, 1'b0);
        // F6: same value unblanked, both dots visible; load 9876
        add( 1, 16'h9876, 4'h0, 1'b0, 4'h0, 4'b1110, 1'b0, 1'b1);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b1101, 1'b1, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b1011, 1'b0, 1'b0);
        add(-1, 16'h0000, 4'h0, 1'b0, 4'h0, 4'b0111, 1'b1, 1'b0);

        rst = 1'b1;
        step();
        step();
        chk("reset hex", 16'(hex), 16'h0);
        chk("reset digit_en", 16'(digit_en), 16'hF);
        chk("reset dp", 16'(dp), 16'd1);
        chk("reset frame_done", 16'(frame_done), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_slot(vecs[i], i);

        // F7 shows 9876; abort the scan with reset during digit 2's slot
        chk("f7 frame_done", 16'(frame_done), 16'd1);
        chk("f7 d0 hex", 16'(hex), 16'h6);
        repeat (10) step();
        chk("f7 d2 hex", 16'(hex), 16'h8);
        chk("f7 d2 digit_en", 16'(digit_en), 16'hB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst digit_en", 16'(digit_en), 16'hF);
        chk("midrst hex", 16'(hex), 16'h0);
        chk("midrst dp", 16'(dp), 16'd1);
        chk("midrst frame_done", 16'(frame_done), 16'd0);
        step();
        chk("restart d0 digit_en", 16'(digit_en), 16'hE);
        chk("restart d0 hex", 16'(hex), 16'h0);
        repeat (3) step();
        chk("restart d1 dead digit_en", 16'(digit_en), 16'hF);
        chk("restart d1 hex", 16'(hex), 16'h0);
        step();
        chk("restart d1 digit_en", 16'(digit_en), 16'hD);
        repeat (11) step();
        chk("restart frame_done", 16'(frame_done), 16'd1);
        chk("restart pending cleared hex", 16'(hex), 16'h0);
        step();
        chk("frame_done width", 16'(frame_done), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
